// File: rtl/krv_uart_rx.sv
// krv_uart_rx: 16x-oversampled UART receiver feeding a show-ahead receive FIFO.
// Build option: define KRV_UART_RX_PARITY_EN to add an even-parity bit (8E1); default is 8N1.
module krv_uart_rx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                        i_cpu_clk,
  input  logic                        i_porn,
  input  logic                        i_uart_rx,
  input  logic                        i_rx_en,
  input  logic [DIV_WIDTH-1:0]        i_baud_div,
  input  logic                        i_rd_en,
  input  logic                        i_err_clr,
  output logic [7:0]                  o_rx_data,
  output logic                        o_rx_valid,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
  output logic                        o_rx_overrun,
  output logic                        o_frame_err,
  output logic                        o_parity_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);

`ifdef KRV_UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               r_state;
  logic [2:0]           r_sync;
  logic [DIV_WIDTH-1:0] r_tcnt;
  logic [3:0]           r_sc;
  logic [2:0]           r_bc;
  logic [7:0]           r_shift;
  logic                 r_push;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_cnt;

  logic w_rxs;
  logic w_fall;
  logic w_start;
  logic w_tick;
  logic w_pop;
  logic w_wr;

  // r_sync[1] is the synchronised line; r_sync[2] is its previous value for edge detection.
  assign w_rxs   = r_sync[1];
  assign w_fall  = r_sync[2] & ~r_sync[1];
  assign w_start = (r_state == StIdle) && i_rx_en && w_fall;
  assign w_tick  = i_rx_en && (r_tcnt == '0);

  always_ff @(posedge i_cpu_clk or negedge i_porn) begin
    if (!i_porn) begin
      r_sync <= 3'b111;
    end else begin
      r_sync <= {r_sync[1:0], i_uart_rx};
    end
  end

  always_ff @(posedge i_cpu_clk or negedge i_porn) begin
    if (!i_porn) begin
      r_tcnt <= '0;
    end else if (w_start) begin
      r_tcnt <= i_baud_div;
    end else if (i_rx_en) begin
      r_tcnt <= w_tick ? i_baud_div : r_tcnt - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge i_cpu_clk or negedge i_porn) begin
    if (!i_porn) begin
      r_state     <= StIdle;
      r_sc        <= '0;
      r_bc        <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (i_err_clr) begin
        r_frame_err <= 1'b0;
      end
      if (!i_rx_en) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_fall) begin
              r_state <= StStart;
              r_sc    <= '0;
            end
          end
          StStart: begin
            if (w_tick) begin
              if (r_sc == 4'd7) begin
                r_sc    <= '0;
                r_bc    <= '0;
                r_state <= w_rxs ? StIdle : StData;
              end else begin
                r_sc <= r_sc + 4'd1;
              end
            end
          end
          StData: begin
            if (w_tick) begin
              r_sc <= r_sc + 4'd1;
              if (r_sc == 4'd15) begin
                r_shift <= {w_rxs, r_shift[7:1]};
                r_bc    <= r_bc + 3'd1;
                if (r_bc == 3'd7) begin
`ifdef KRV_UART_RX_PARITY_EN
                  r_state <= StPar;
`else
                  r_state <= StStop;
`endif
                end
              end
            end
          end
`ifdef KRV_UART_RX_PARITY_EN
          StPar: begin
            if (w_tick) begin
              r_sc <= r_sc + 4'd1;
              if (r_sc == 4'd15) begin
                r_state <= StStop;
              end
            end
          end
`endif
          StStop: begin
            if (w_tick) begin
              r_sc <= r_sc + 4'd1;
              if (r_sc == 4'd15) begin
                r_state <= StIdle;
                if (w_rxs) begin
                  r_push <= 1'b1;
                end else begin
                  r_frame_err <= 1'b1;
                end
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

`ifdef KRV_UART_RX_PARITY_EN
  logic r_parity_err;

  // Parity is judged on its own sample; the byte still goes out if the stop bit is good.
  always_ff @(posedge i_cpu_clk or negedge i_porn) begin
    if (!i_porn) begin
      r_parity_err <= 1'b0;
    end else begin
      if (i_err_clr) begin
        r_parity_err <= 1'b0;
      end
      if (i_rx_en && (r_state == StPar) && w_tick && (r_sc == 4'd15) && (w_rxs != ^r_shift)) begin
        r_parity_err <= 1'b1;
      end
    end
  end

  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

  // A full FIFO still accepts a push when the same edge pops the head.
  assign w_pop = i_rd_en && (r_cnt != '0);
  assign w_wr  = r_push && ((r_cnt != FullCnt) || w_pop);

  always_ff @(posedge i_cpu_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  always_ff @(posedge i_cpu_clk or negedge i_porn) begin
    if (!i_porn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + (AW+1)'(1);
      end else if (!w_wr && w_pop) begin
        r_cnt <= r_cnt - (AW+1)'(1);
      end
      if (i_err_clr) begin
        r_overrun <= 1'b0;
      end
      if (r_push && !w_wr) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_rx_valid   = (r_cnt != '0);
  assign o_rx_data    = o_rx_valid ? r_mem[r_rptr] : 8'h00;
  assign o_fifo_cnt   = r_cnt;
  assign o_rx_overrun = r_overrun;
  assign o_frame_err  = r_frame_err;

endmodule

// File: doc/krv_uart_rx.md
# krv_uart_rx

UART receiver for the krv_c SoC peripheral subsystem. It deserialises the `UART_RX` pad, which the SoC bench drives idle-high, into bytes and buffers them in a small show-ahead FIFO that the core's UART register slave pops. It sits directly downstream of the `UART_RX` top-level pin and upstream of the UART register bank.

## Interface
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two, minimum 2.
- `DIV_WIDTH`, default 16: width of the baud divisor.
- `cpu_clk  in  1`: core clock; all logic is on its rising edge.
- `porn  in  1`: reset, asynchronous, active-low.
- `uart_rx  in  1`: serial input, asynchronous to `cpu_clk`, idle high.
- `rx_en  in  1`: receiver enable.
- `baud_div  in  DIV_WIDTH`: oversample tick period minus 1, in `cpu_clk` cycles. One bit is 16 ticks.
- `rd_en  in  1`: pop the FIFO head; single-cycle pulse.
- `err_clr  in  1`: clears the sticky error flags.
- `rx_data  out  8`: FIFO head byte; 0 when empty.
- `rx_valid  out  1`: FIFO not empty.
- `fifo_cnt  out  log2(FIFO_DEPTH)+1`: occupancy.
- `rx_overrun  out  1`: sticky; a byte was dropped because the FIFO was full.
- `frame_err  out  1`: sticky; a stop bit was sampled low.
- `parity_err  out  1`: sticky; tied 0 unless parity is compiled in.

## Operation
- **Reset:**
  - all outputs are 0.
  - synchroniser flops are 1.
  - FSM is in IDLE, FIFO is empty, tick counter is 0.
- **Synchroniser:** `uart_rx` passes through 2 flops to give `rxs`. Edge detect uses a third flop.
- **Tick counter:**
  - runs only when `rx_en`=1.
  - counts down from `baud_div`; `tick` is asserted when the count is 0, then the counter reloads.
  - reloads to `baud_div` on leaving IDLE, so the start bit is aligned.
- **FSM states:** IDLE, START, DATA, PAR (only with the macro), STOP. A 4-bit sample counter `sc` counts ticks; a 3-bit counter `bc` counts data bits.
  - **IDLE:** a falling edge on `rxs` with `rx_en`=1 moves to START with `sc`=0. A line held low (break) does not retrigger, because an edge is required.
  - **START:** at the tick where `sc`=7, `rxs`=0 moves to DATA with `sc`=0; `rxs`=1 is a glitch and returns to IDLE with no flag.
  - **DATA:** at the tick where `sc`=15, shift `rxs` into bit 7 of the shift register, shifting right (LSB first). After 8 bits go to PAR or STOP.
  - **STOP:** at the tick where `sc`=15:
    - `rxs`=1: push the byte and return to IDLE.
    - `rxs`=0: set `frame_err`, discard the byte, return to IDLE.
- **rx_en:** deasserting it forces IDLE in the next cycle and abandons any partial byte. FIFO contents and flags are kept.
- **FIFO:**
  - show-ahead: `rx_data` is the head entry.
  - `rd_en` while empty is ignored.
  - push while full, without a simultaneous pop: byte dropped, `rx_overrun` set.
  - push and pop in the same cycle while full: both are accepted and `fifo_cnt` is unchanged.
  - pointers wrap modulo `FIFO_DEPTH`.
- **Error flags:** `err_clr` clears all flags. If a flag is set in the same cycle as `err_clr`, set wins.

## Timing
- A push occurs on the `cpu_clk` edge of the STOP mid-bit tick. `rx_valid` and `rx_data` update on the next edge.
- Pad-to-FSM latency is 2 cycles.
- Frame length with no parity is 16×(`baud_div`+1)×9.5 cycles from the start edge to the push.
- `rd_en` at edge N: `rx_data` shows the next entry (or 0) after edge N.
- A `baud_div` change takes effect at the next reload. Software changes it only while `rx_en`=0.
- Reset asserted mid-frame discards the frame immediately (asynchronous).

## Configuration
- **`KRV_UART_RX_PARITY_EN` defined:**
  - the PAR state is included, even parity, sampled at `sc`=15.
  - a mismatch sets `parity_err`; the byte is still pushed if the stop bit is good.
  - frame is 10.5 bit-times to the push.
- **Not defined:**
  - no PAR state; 8N1 only.
  - `parity_err` is constant 0.

## Test plan
- **8N1 receive:** `baud_div`=0, `rx_en`=1, drive 0xA5 at 16 cycles per bit → `rx_valid`=1 and `rx_data`=0xA5 about 152 cycles after the start edge; `fifo_cnt`=1; flags stay 0.
- **Start glitch:** a 4-cycle low pulse on `uart_rx` → FSM returns to IDLE, no push, no flags. Then send 0x3C → received correctly.
- **Frame error:** send 0x55 with the stop bit low → `frame_err`=1, `fifo_cnt`=0. Hold the line low 300 cycles → no new frame. `err_clr` → flag 0.
- **Overrun and wrap:**
  - with `FIFO_DEPTH`=4, send 0x01..0x05 without reading → `fifo_cnt`=4, `rx_overrun`=1.
  - pop 4 times → reads 0x01..0x04.
  - send 6 more and pop all → data in order across the pointer wrap.
- **Full push plus pop:** with the FIFO full, pulse `rd_en` on the push edge of 0x77 → `fifo_cnt` stays 4, `rx_overrun` not set, and 0x77 is last out.
- **Parity (macro on):** send 0x03 with parity bit 1 → `parity_err`=1 and 0x03 pushed. Send 0x03 with parity bit 0 → no flag.
